// File: rtl/classificador_zona_12_if.sv
// Handshake, threshold-write and result signals of the zone classifier.
// The classifier drives outputs through the slave modport; its client uses the master modport.
interface classificador_zona_12_if;
    logic        iniciar;
    logic        continuo;
    logic [11:0] medida;
    logic        escreve_limiar;
    logic [1:0]  endereco_limiar;
    logic [11:0] dado_limiar;
    logic        ocupado;
    logic        pronto;
    logic [2:0]  zona;
    logic [3:0]  mascara;
    logic        igual;
    logic        erro_escrita;

    modport master (
        output iniciar, continuo, medida, escreve_limiar, endereco_limiar, dado_limiar,
        input  ocupado, pronto, zona, mascara, igual, erro_escrita
    );

    modport slave (
        input  iniciar, continuo, medida, escreve_limiar, endereco_limiar, dado_limiar,
        output ocupado, pronto, zona, mascara, igual, erro_escrita
    );
endinterface

// File: rtl/classificador_zona_12.sv
// Classifies a latched 12-bit measurement against four programmable thresholds,
// one shared magnitude comparison per clock, reporting zone, mask and equality.
module classificador_zona_12 #(
    parameter logic [11:0] LIM0 = 12'd100,
    parameter logic [11:0] LIM1 = 12'd200,
    parameter logic [11:0] LIM2 = 12'd400,
    parameter logic [11:0] LIM3 = 12'd800
) (
    input logic                   clock,
    input logic                   reset,
    classificador_zona_12_if.slave bus
);
    typedef enum logic [1:0] {INICIAL, CARREGA, COMPARA, FIM} estado_t;

    estado_t     estado;
    logic [11:0] medida_reg;
    logic [11:0] limiar [4];
    logic [1:0]  indice;
    logic [3:0]  masc_acc;
    logic        igual_acc;

    logic        maior_igual;
    logic        iguais;
    logic [3:0]  masc_prox;
    logic        igual_prox;

    function automatic logic [2:0] conta_uns(input logic [3:0] m);
        logic [2:0] n;
        n = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            n = n + {2'b00, m[k]};
        end
        return n;
    endfunction

    // Last comparison feeds the published results directly, so FIM is entered with final values.
    always_comb begin
        maior_igual       = medida_reg >= limiar[indice];
        iguais            = medida_reg == limiar[indice];
        masc_prox         = masc_acc;
        masc_prox[indice] = maior_igual;
        igual_prox        = igual_acc | iguais;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado           <= INICIAL;
            medida_reg       <= '0;
            limiar[0]        <= LIM0;
            limiar[1]        <= LIM1;
            limiar[2]        <= LIM2;
            limiar[3]        <= LIM3;
            indice           <= '0;
            masc_acc         <= '0;
            igual_acc        <= 1'b0;
            bus.ocupado      <= 1'b0;
            bus.pronto       <= 1'b0;
            bus.zona         <= '0;
            bus.mascara      <= '0;
            bus.igual        <= 1'b0;
            bus.erro_escrita <= 1'b0;
        end else begin
            bus.pronto       <= 1'b0;
            bus.erro_escrita <= bus.escreve_limiar && (estado != INICIAL);
            case (estado)
                INICIAL: begin
                    if (bus.escreve_limiar) begin
                        limiar[bus.endereco_limiar] <= bus.dado_limiar;
                    end
                    if (bus.iniciar) begin
                        estado      <= CARREGA;
                        bus.ocupado <= 1'b1;
                    end
                end
                CARREGA: begin
                    medida_reg <= bus.medida;
                    indice     <= '0;
                    masc_acc   <= '0;
                    igual_acc  <= 1'b0;
                    estado     <= COMPARA;
                end
                COMPARA: begin
                    masc_acc  <= masc_prox;
                    igual_acc <= igual_prox;
                    indice    <= indice + 2'd1;
                    if (indice == 2'd3) begin
                        estado      <= FIM;
                        bus.mascara <= masc_prox;
                        bus.igual   <= igual_prox;
                        bus.zona    <= conta_uns(masc_prox);
                        bus.pronto  <= 1'b1;
                    end
                end
                FIM: begin
                    if (bus.continuo) begin
                        estado <= CARREGA;
                    end else begin
                        estado      <= INICIAL;
                        bus.ocupado <= 1'b0;
                    end
                end
                default: estado <= INICIAL;
            endcase
        end
    end
endmodule

// File: tb/tb_classificador_zona_12.sv
// Self-checking bench for classificador_zona_12: directed scenarios plus randomized
// classifications checked against a threshold-array reference model.
module tb_classificador_zona_12;
    logic clock = 1'b0;
    logic reset = 1'b1;

    classificador_zona_12_if bus ();

    classificador_zona_12 #(
        .LIM0(12'd100),
        .LIM1(12'd200),
        .LIM2(12'd400),
        .LIM3(12'd800)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    int unsigned n_vetores = 0;
    int unsigned n_erros   = 0;
    logic [11:0] lim_ref [4];

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_vetores++;
        if (obs !== esp) begin
            n_erros++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, esp, $time);
        end
    endtask

    task automatic lim_padrao();
        lim_ref[0] = 12'd100;
        lim_ref[1] = 12'd200;
        lim_ref[2] = 12'd400;
        lim_ref[3] = 12'd800;
    endtask

    function automatic void modelo(input logic [11:0] m, output logic [2:0] z,
                                   output logic [3:0] mk, output logic ig);
        z = '0; mk = '0; ig = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m >= lim_ref[i]) begin
                mk[i] = 1'b1;
                z     = z + 3'd1;
            end
            if (m == lim_ref[i]) ig = 1'b1;
        end
    endfunction

    task automatic confere_saidas(input string tag, input logic [11:0] m);
        logic [2:0] z; logic [3:0] mk; logic ig;
        modelo(m, z, mk, ig);
        verifica({tag, "_zona"},    32'(bus.zona),    32'(z));
        verifica({tag, "_mascara"}, 32'(bus.mascara), 32'(mk));
        verifica({tag, "_igual"},   32'(bus.igual),   32'(ig));
    endtask

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    // One single-shot classification; optionally disturbs it with a write and iniciar during COMPARA.
    task automatic classificar(input logic [11:0] m, input bit wr, input logic [1:0] a,
                               input logic [11:0] d, input bit perturba);
        bus.medida          = m;
        bus.iniciar         = 1'b1;
        bus.escreve_limiar  = wr;
        bus.endereco_limiar = a;
        bus.dado_limiar     = d;
        ciclo();
        if (wr) lim_ref[a] = d;
        bus.iniciar        = 1'b0;
        bus.escreve_limiar = 1'b0;
        verifica("ocupado_e0", 32'(bus.ocupado), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            ciclo();
            if (c == 1) bus.medida = 12'($urandom);
            if (perturba && c == 2) begin
                bus.escreve_limiar  = 1'b1;
                bus.endereco_limiar = 2'd2;
                bus.dado_limiar     = 12'd0;
                bus.iniciar         = 1'b1;
            end
            if (perturba && c == 3) begin
                bus.escreve_limiar = 1'b0;
                bus.iniciar        = 1'b0;
                verifica("erro_escrita_pulso", 32'(bus.erro_escrita), 32'd1);
            end
            if (perturba && c == 4) verifica("erro_escrita_fim", 32'(bus.erro_escrita), 32'd0);
            verifica("pronto", 32'(bus.pronto), (c == 5) ? 32'd1 : 32'd0);
            verifica("ocupado", 32'(bus.ocupado), (c < 6) ? 32'd1 : 32'd0);
            if (c == 5) confere_saidas("res", m);
        end
    endtask

    logic [11:0] seq_cont [3];

    initial begin
        bus.iniciar = 0; bus.continuo = 0; bus.medida = '0;
        bus.escreve_limiar = 0; bus.endereco_limiar = '0; bus.dado_limiar = '0;
        lim_padrao();
        ciclo();
        ciclo();
        verifica("rst_ocupado", 32'(bus.ocupado), 32'd0);
        verifica("rst_pronto",  32'(bus.pronto),  32'd0);
        verifica("rst_zona",    32'(bus.zona),    32'd0);
        verifica("rst_mascara", 32'(bus.mascara), 32'd0);
        verifica("rst_igual",   32'(bus.igual),   32'd0);
        verifica("rst_erro",    32'(bus.erro_escrita), 32'd0);
        reset = 1'b0;
        ciclo();

        classificar(12'd300,  0, 2'd0, 12'd0, 0);
        classificar(12'd800,  0, 2'd0, 12'd0, 0);
        classificar(12'd0,    0, 2'd0, 12'd0, 0);
        classificar(12'd4095, 0, 2'd0, 12'd0, 0);
        classificar(12'd60,   1, 2'd1, 12'd50, 0);
        verifica("wr1_mascara", 32'(bus.mascara), 32'd2);
        // Thresholds are now non-monotonic (lim[1]=50 < lim[0]).
        bus.escreve_limiar = 1'b1; bus.endereco_limiar = 2'd0; bus.dado_limiar = 12'd0;
        ciclo();
        lim_ref[0] = 12'd0;
        bus.escreve_limiar = 1'b0;
        verifica("erro_em_inicial", 32'(bus.erro_escrita), 32'd0);
        classificar(12'd0, 0, 2'd0, 12'd0, 0);
        verifica("wr0_igual", 32'(bus.igual), 32'd1);

        lim_padrao();
        for (int i = 0; i < 2; i++) begin
            bus.escreve_limiar = 1'b1; bus.endereco_limiar = 2'(i); bus.dado_limiar = lim_ref[i];
            ciclo();
        end
        bus.escreve_limiar = 1'b0;
        classificar(12'd300, 0, 2'd0, 12'd0, 1);
        classificar(12'd300, 0, 2'd0, 12'd0, 0);
        verifica("apos_perturba_zona", 32'(bus.zona), 32'd2);

        // Continuous mode: three back-to-back runs, continuo dropped during the last one.
        seq_cont[0] = 12'd150; seq_cont[1] = 12'd450; seq_cont[2] = 12'd900;
        bus.continuo = 1'b1;
        bus.medida   = seq_cont[0];
        bus.iniciar  = 1'b1;
        ciclo();
        bus.iniciar = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            ciclo();
            if (c == 1) bus.medida = seq_cont[1];
            if (c == 7) bus.medida = seq_cont[2];
            if (c == 12) bus.continuo = 1'b0;
            verifica("cont_pronto", 32'(bus.pronto),
                     (c == 5 || c == 11 || c == 17) ? 32'd1 : 32'd0);
            verifica("cont_ocupado", 32'(bus.ocupado), (c < 18) ? 32'd1 : 32'd0);
            if (c == 5)  confere_saidas("cont0", seq_cont[0]);
            if (c == 11) confere_saidas("cont1", seq_cont[1]);
            if (c == 17) confere_saidas("cont2", seq_cont[2]);
        end

        // Asynchronous reset in the middle of a run, after writing a threshold.
        bus.escreve_limiar = 1'b1; bus.endereco_limiar = 2'd1; bus.dado_limiar = 12'd4000;
        bus.medida = 12'd150; bus.iniciar = 1'b1;
        ciclo();
        bus.escreve_limiar = 1'b0; bus.iniciar = 1'b0;
        ciclo(); ciclo(); ciclo();
        reset = 1'b1;
        #1;
        verifica("arst_ocupado", 32'(bus.ocupado), 32'd0);
        verifica("arst_pronto",  32'(bus.pronto),  32'd0);
        verifica("arst_zona",    32'(bus.zona),    32'd0);
        verifica("arst_mascara", 32'(bus.mascara), 32'd0);
        ciclo();
        reset = 1'b0;
        lim_padrao();
        for (int c = 0; c < 6; c++) begin
            ciclo();
            verifica("arst_sem_pronto", 32'(bus.pronto), 32'd0);
        end
        classificar(12'd150, 0, 2'd0, 12'd0, 0);
        verifica("arst_zona1", 32'(bus.zona), 32'd1);

        // Randomized classifications with occasional threshold writes in INICIAL.
        for (int n = 0; n < 40; n++) begin
            logic [11:0] m;
            logic [1:0]  a;
            logic [11:0] d;
            a = 2'($urandom_range(0, 3));
            d = 12'($urandom);
            if ($urandom_range(0, 2) == 0) m = lim_ref[$urandom_range(0, 3)];
            else                            m = 12'($urandom);
            classificar(m, ($urandom_range(0, 3) == 0), a, d, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
        $finish;
    end
endmodule
